// File: rtl/cp0_pkg.sv
// Shared CP0-side definitions: redirect FSM encoding, exception vectors, flush bit map.
package cp0_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_DRAIN    = 2'd3
    } state_t;

    localparam logic [31:0] VEC_BEV1_DEF = 32'hBFC0_0380;
    localparam logic [31:0] VEC_BEV0_DEF = 32'h8000_0180;

    localparam int FL_IF  = 0;
    localparam int FL_ID  = 1;
    localparam int FL_EX  = 2;
    localparam int FL_MEM = 3;

endpackage

// File: rtl/exc_redirect.sv
// Turns CP0 exception / ERET edges into flush -> redirect handshake -> drain sequences.
// Outputs decode registered state only; a redirect is held until if_ready.
module exc_redirect
    import cp0_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter logic [31:0] VEC_BEV1     = VEC_BEV1_DEF,
    parameter logic [31:0] VEC_BEV0     = VEC_BEV0_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc,
    input  logic        back,
    input  logic [31:0] epc,
    input  logic        status_bev,
    input  logic        if_ready,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [3:0]  flush,
    output logic        busy,
    output logic [15:0] exc_cnt
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t      state_q, state_d;
    logic        exc_q, back_q;
    logic [31:0] target_q, target_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [3:0]  drain_q, drain_d;
    logic [15:0] exc_cnt_q, exc_cnt_d;

    logic        exc_rise, eret_rise;
    logic [31:0] exc_vec;

    assign exc_rise  = exc & ~exc_q;
    assign eret_rise = back & ~back_q;
    assign exc_vec   = status_bev ? VEC_BEV1 : VEC_BEV0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            exc_q         <= 1'b0;
            back_q        <= 1'b0;
            target_q      <= VEC_BEV1;
            pend_q        <= 1'b0;
            pend_target_q <= VEC_BEV1;
            drain_q       <= 4'd0;
            exc_cnt_q     <= 16'd0;
        end else begin
            state_q       <= state_d;
            exc_q         <= exc;
            back_q        <= back;
            target_q      <= target_d;
            pend_q        <= pend_d;
            pend_target_q <= pend_target_d;
            drain_q       <= drain_d;
            exc_cnt_q     <= exc_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        pend_d        = pend_q;
        pend_target_d = pend_target_q;
        drain_d       = drain_q;
        exc_cnt_d     = exc_cnt_q;

        // Exceptions arriving mid-sequence are queued one deep; ERETs are simply dropped.
        if (state_q != ST_IDLE && exc_rise && !pend_q) begin
            pend_d        = 1'b1;
            pend_target_d = exc_vec;
            exc_cnt_d     = exc_cnt_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (exc_rise) begin
                    target_d  = exc_vec;
                    exc_cnt_d = exc_cnt_q + 16'd1;
                    state_d   = ST_FLUSH;
                end else if (eret_rise) begin
                    target_d = epc;
                    state_d  = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (if_ready) begin
                    drain_d = DRAIN_LOAD;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_q == 4'd0) begin
                    // A pend raised on this very cycle still chains, so it is never stranded.
                    if (pend_d) begin
                        target_d = pend_target_d;
                        pend_d   = 1'b0;
                        state_d  = ST_FLUSH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        flush          = 4'b0000;
        redirect_valid = 1'b0;
        busy           = (state_q != ST_IDLE);
        redirect_pc    = target_q;
        exc_cnt        = exc_cnt_q;
        case (state_q)
            ST_FLUSH: flush = 4'b1111;
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                flush[FL_IF]   = 1'b1;
                flush[FL_ID]   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exc_redirect.sv
// Directed bench: stimulus pushes expected redirect targets, a monitor pops them on each handshake.
module tb_exc_redirect;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exc = 1'b0;
    logic        back = 1'b0;
    logic [31:0] epc = 32'd0;
    logic        status_bev = 1'b0;
    logic        if_ready = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [3:0]  flush;
    logic        busy;
    logic [15:0] exc_cnt;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    exc_redirect #(
        .DRAIN_CYCLES (2),
        .VEC_BEV1     (32'hBFC0_0380),
        .VEC_BEV0     (32'h8000_0180)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .exc            (exc),
        .back           (back),
        .epc            (epc),
        .status_bev     (status_bev),
        .if_ready       (if_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .busy           (busy),
        .exc_cnt        (exc_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted redirect must match the oldest expected target.
    always @(negedge clk) begin
        if (!rst && redirect_valid && if_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_redirect: got pc %h expected none", redirect_pc);
            end else begin
                chk("redirect_pc_sb", redirect_pc, exp_q.pop_front());
            end
        end
    end

    initial begin
        // reset state
        tick(); tick();
        chk("rst_valid", 32'(redirect_valid), 32'd0);
        chk("rst_pc", redirect_pc, 32'hBFC0_0380);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(exc_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // exception, BEV=1, immediate accept
        exc = 1'b1; status_bev = 1'b1; if_ready = 1'b1;
        exp_q.push_back(32'hBFC0_0380);
        tick();
        chk("t1_flush_all", 32'(flush), 32'hF);
        chk("t1_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_valid", 32'(redirect_valid), 32'd1);
        chk("t1_pc", redirect_pc, 32'hBFC0_0380);
        chk("t1_flush_ifid", 32'(flush), 32'h3);
        tick();
        chk("t1_drain_flush", 32'(flush), 32'h0);
        chk("t1_drain_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_drain2_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_idle", 32'(busy), 32'd0);
        chk("t1_cnt", 32'(exc_cnt), 32'd1);
        exc = 1'b0;
        tick();

        // ERET with fetch stalled for three cycles
        back = 1'b1; epc = 32'h8000_1234; if_ready = 1'b0;
        exp_q.push_back(32'h8000_1234);
        tick();
        chk("t2_flush_all", 32'(flush), 32'hF);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t2_hold_valid", 32'(redirect_valid), 32'd1);
            chk("t2_hold_pc", redirect_pc, 32'h8000_1234);
            chk("t2_hold_flush", 32'(flush), 32'h3);
            tick();
        end
        if_ready = 1'b1;
        tick(); tick(); tick();
        chk("t2_idle", 32'(busy), 32'd0);
        chk("t2_cnt", 32'(exc_cnt), 32'd1);
        back = 1'b0;
        tick();

        // exception and ERET together: exception wins, single sequence
        exc = 1'b1; back = 1'b1; status_bev = 1'b0; epc = 32'h1111_2222;
        exp_q.push_back(32'h8000_0180);
        tick();
        chk("t3_flush_all", 32'(flush), 32'hF);
        tick();
        chk("t3_pc", redirect_pc, 32'h8000_0180);
        tick(); tick(); tick();
        chk("t3_idle", 32'(busy), 32'd0);
        tick(); tick();
        chk("t3_no_second", 32'(busy), 32'd0);
        chk("t3_cnt", 32'(exc_cnt), 32'd2);
        exc = 1'b0; back = 1'b0;
        tick();

        // second exception during DRAIN chains straight into FLUSH
        exc = 1'b1; status_bev = 1'b1;
        exp_q.push_back(32'hBFC0_0380);
        tick();
        chk("t4_cnt_first", 32'(exc_cnt), 32'd3);
        exc = 1'b0;
        tick();
        tick();
        exc = 1'b1; status_bev = 1'b0;
        exp_q.push_back(32'h8000_0180);
        tick();
        chk("t4_cnt_pend", 32'(exc_cnt), 32'd4);
        chk("t4_still_drain", 32'(busy), 32'd1);
        tick();
        chk("t4_chain_flush", 32'(flush), 32'hF);
        chk("t4_chain_busy", 32'(busy), 32'd1);
        tick();
        chk("t4_pc2", redirect_pc, 32'h8000_0180);
        tick(); tick(); tick();
        chk("t4_idle", 32'(busy), 32'd0);
        exc = 1'b0;
        tick();

        // reset while a redirect is being held
        exc = 1'b1; status_bev = 1'b0; if_ready = 1'b0;
        tick(); tick();
        chk("t5_valid_pre", 32'(redirect_valid), 32'd1);
        rst = 1'b1; exc = 1'b0;
        tick();
        chk("t5_valid", 32'(redirect_valid), 32'd0);
        chk("t5_flush", 32'(flush), 32'h0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_cnt", 32'(exc_cnt), 32'd0);
        chk("t5_pc", redirect_pc, 32'hBFC0_0380);
        rst = 1'b0;
        tick();

        // held exception level produces exactly one sequence
        exc = 1'b1; status_bev = 1'b0; if_ready = 1'b1;
        exp_q.push_back(32'h8000_0180);
        repeat (10) tick();
        exc = 1'b0;
        repeat (4) tick();
        chk("t6_cnt", 32'(exc_cnt), 32'd1);
        chk("t6_idle", 32'(busy), 32'd0);

        // counter wrap
        dut.exc_cnt_q = 16'hFFFF;
        exc = 1'b1; status_bev = 1'b1;
        exp_q.push_back(32'hBFC0_0380);
        tick();
        chk("t7_wrap", 32'(exc_cnt), 32'd0);
        repeat (5) tick();
        chk("t7_idle", 32'(busy), 32'd0);
        exc = 1'b0;
        tick();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exc_redirect.md
# exc_redirect

Pipeline-side consumer of the coprocessor-0 exception interface. It takes the exception and ERET indications produced by CP0 and turns each one into a fixed sequence of actions:
- flush the in-flight pipeline stages;
- hand a redirect PC to the fetch unit with a valid/ready handshake;
- hold off further requests while the pipeline drains.

It sits between CP0 and the IF stage, alongside the normal branch next-PC logic, and has priority over it.

## Interface
Parameters:
- DRAIN_CYCLES, 2: cycles spent in DRAIN after the redirect is accepted (1..15).
- VEC_BEV1, 32'hBFC00380: exception vector when Status.BEV=1.
- VEC_BEV0, 32'h80000180: exception vector when Status.BEV=0.

Ports:
- Reset behaviour (already decided): one clock; reset is synchronous and active-high.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- exc  in  1  CP0 exception-taken level; a rising edge is one request.
- back  in  1  ERET-in-stage-2 level; a rising edge is one request.
- epc  in  32  CP0 EPC, sampled when an ERET is accepted.
- status_bev  in  1  Status[22], sampled when an exception is accepted.
- if_ready  in  1  fetch unit accepts redirect_pc this cycle.
- redirect_valid  out  1  redirect_pc is valid; held until if_ready.
- redirect_pc  out  32  target PC.
- flush  out  4  per-stage flush: [0] IF, [1] ID, [2] EX, [3] MEM.
- busy  out  1  high in any state other than IDLE.
- exc_cnt  out  16  count of accepted exceptions; wraps at 16'hFFFF→0.

## Operation
- Edge detect: registers exc_q and back_q.
  - exc_rise = exc & ~exc_q; eret_rise = back & ~back_q.
  - Both registers clear on rst.
- FSM states: IDLE, FLUSH, REDIRECT, DRAIN.
- IDLE:
  - exc_rise: latch target = status_bev ? VEC_BEV1 : VEC_BEV0; increment exc_cnt; go to FLUSH.
  - else eret_rise: latch target = epc; go to FLUSH.
  - If both rise in the same cycle, the exception wins and the ERET is dropped.
- FLUSH: flush=4'b1111 for exactly one cycle; go to REDIRECT.
- REDIRECT:
  - redirect_valid=1 and redirect_pc=target, held stable until a cycle where if_ready=1.
  - On that cycle go to DRAIN and load the drain counter with DRAIN_CYCLES-1.
  - flush=4'b0011 every REDIRECT cycle, so stale IF/ID instructions are squashed while fetch stalls.
- DRAIN:
  - flush=0; the counter decrements each cycle.
  - At 0, go to IDLE, except when an exception is pending (below), in which case go straight to FLUSH.
- Pending exception:
  - A one-deep pend_exc flag is set by exc_rise in any non-IDLE state.
  - Its vector is recomputed from status_bev at the moment it is set, and exc_cnt increments then.
  - Further exc_rise while pend_exc=1 is ignored (no count).
  - pend_exc clears on entry to FLUSH.
- eret_rise in any non-IDLE state is dropped.
- redirect_pc holds its last target outside REDIRECT; only redirect_valid qualifies it.

## Timing
- Reset values: state IDLE, redirect_valid 0, redirect_pc VEC_BEV1, flush 4'b0000, busy 0, exc_cnt 0, pend_exc 0, exc_q/back_q 0.
- All outputs are decoded from registered state/target, so there is no combinational path from inputs to outputs.
- exc rises before edge N → state FLUSH after edge N (flush=1111 in cycle N+1).
- REDIRECT is entered after edge N+1; redirect_valid is first high in cycle N+2.
- With if_ready=1 in cycle N+2: DRAIN lasts cycles N+3..N+2+DRAIN_CYCLES, and busy=0 in cycle N+3+DRAIN_CYCLES.
- if_ready is ignored outside REDIRECT.
- rst asserted in any state returns everything to reset values at the next edge, including a partially held redirect.
- A request edge present in the reset cycle is lost, because exc_q/back_q also clear.

## Structure
- Shared package cp0_pkg holds:
  - the state enum localparams;
  - the VEC_BEV1/VEC_BEV0 defaults;
  - flush bit indices FL_IF=0, FL_ID=1, FL_EX=2, FL_MEM=3.
- Single module; no sub-module is needed. The drain counter is 4 bits, inline.

## Test plan
- exc 0→1 with status_bev=1, if_ready=1 → flush=1111 in cycle +1; redirect_valid with redirect_pc=BFC00380 in +2; busy=0 in +5 (DRAIN_CYCLES=2); exc_cnt=1.
- back 0→1 with epc=0x80001234, if_ready low for 3 cycles → redirect_pc held at 0x80001234 with flush=0011 each of those cycles; exc_cnt unchanged.
- exc and back rise together with status_bev=0 → single redirect to 80000180; no second sequence.
- exc rises again during DRAIN → pend_exc set, exc_cnt=2; FLUSH follows DRAIN directly with no IDLE cycle between.
- rst during REDIRECT → next cycle redirect_valid=0, flush=0, busy=0, exc_cnt=0.
- exc held high for 10 cycles → exactly one sequence; exc_cnt at 16'hFFFF plus one exception → 0.
